me_result_collector: RTL and testbench

//  Downstream stage of the IDDMM modular-exponentiation core. Launches one exponentiation job via me_start,

---
 rtl/me_pkg.sv | 18 +
 rtl/me_result_collector.sv | 124 ++++++++++++
 tb/tb_me_result_collector.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the modular-exponentiation result path: default geometry,
// word-counter width derivation and the collector state encoding.
package me_pkg;

  localparam int ME_K = 128;
  localparam int ME_N = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } me_state_e;

  function automatic int me_addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/me_result_collector.sv
// Launches one exponentiation job, gathers the N result words the core emits and
// presents the assembled K*N-bit result on a valid/ready handshake.
module me_result_collector
  import me_pkg::*;
#(
  parameter int K       = ME_K,
  parameter int N       = ME_N,
  parameter int TO_W    = 24,
  parameter int TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  output logic           me_start,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid,
  output logic [K*N-1:0] res_data,
  output logic           res_valid,
  input  logic           res_ready,
  input  logic           abort,
  output logic           busy,
  output logic           err_stray,
  output logic           err_timeout
);

  localparam int ADDR_W = me_addr_w(N);
  localparam int WC_W   = ADDR_W + 1;

  me_state_e         state, state_nxt;
  logic [WC_W-1:0]   wcnt, wcnt_nxt;
  logic [TO_W-1:0]   wd, wd_nxt, wd_inc;
  logic              start_nxt, rvld_nxt, tmo_nxt, stray_nxt, wr_en;
  logic              last_word, wd_expired;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_COLLECT) || (state == ST_HOLD);
  assign last_word  = (wcnt == WC_W'(N - 1));
  // Watchdog saturates at all-ones so a disabled or huge limit never wraps back to zero.
  assign wd_inc     = (&wd) ? wd : wd + TO_W'(1);
  assign wd_expired = (TIMEOUT != 0) && (wd_inc >= TO_W'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    wd_nxt    = wd;
    start_nxt = 1'b0;
    rvld_nxt  = res_valid;
    tmo_nxt   = 1'b0;
    stray_nxt = me_valid && (state != ST_COLLECT);
    wr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && req_valid) begin
          start_nxt = 1'b1;
          state_nxt = ST_COLLECT;
          wcnt_nxt  = '0;
          wd_nxt    = '0;
        end
      end
      ST_COLLECT: begin
        // Abort outranks both the final word and watchdog expiry.
        if (abort) begin
          state_nxt = ST_IDLE;
          rvld_nxt  = 1'b0;
        end else if (me_valid) begin
          wr_en    = 1'b1;
          wcnt_nxt = wcnt + WC_W'(1);
          wd_nxt   = '0;
          if (last_word) begin
            state_nxt = ST_HOLD;
            rvld_nxt  = 1'b1;
          end
        end else begin
          wd_nxt = wd_inc;
          if (wd_expired) begin
            tmo_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (abort || res_ready) begin
          state_nxt = ST_IDLE;
          rvld_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rvld_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      wd          <= '0;
      me_start    <= 1'b0;
      res_valid   <= 1'b0;
      err_stray   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      wd          <= wd_nxt;
      me_start    <= start_nxt;
      res_valid   <= rvld_nxt;
      err_stray   <= stray_nxt;
      err_timeout <= tmo_nxt;
    end
  end

  // Only the addressed slice is written; the rest keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (wr_en) begin
      res_data[K*int'(wcnt[ADDR_W-1:0]) +: K] <= me_result;
    end
  end

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector at K=8, N=4, TIMEOUT=20.
module tb_me_result_collector;

  localparam int K = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           me_start;
  logic [K-1:0]   me_result;
  logic           me_valid;
  logic [K*N-1:0] res_data;
  logic           res_valid;
  logic           res_ready;
  logic           abort;
  logic           busy;
  logic           err_stray;
  logic           err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  me_result_collector #(.K(K), .N(N), .TO_W(24), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .me_start(me_start), .me_result(me_result), .me_valid(me_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .abort(abort), .busy(busy), .err_stray(err_stray), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [K-1:0] d);
    me_valid  = 1'b1;
    me_result = d;
    cyc();
    me_valid  = 1'b0;
  endtask

  task automatic start_job();
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; me_valid = 0; me_result = '0; res_ready = 0; abort = 0;
    cyc(); cyc();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({me_start, res_valid, busy, err_stray, err_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL rst_outs got %b want 00000", {me_start, res_valid, busy, err_stray, err_timeout}); end
    n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 00000000", res_data); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    n_cmp++; if (me_start !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL t1_start got start=%b busy=%b rdy=%b want 1 1 0", me_start, busy, req_ready); end
    send_word(8'h11);
    n_cmp++; if (me_start !== 1'b0) begin n_bad++; $display("FAIL t1_start_pulse got %b want 0", me_start); end
    send_word(8'h22);
    send_word(8'h33);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early_valid got %b want 0", res_valid); end
    send_word(8'h44);
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid got %b want 1", res_valid); end
    n_cmp++; if (res_data !== 32'h44332211) begin n_bad++; $display("FAIL t1_data got %h want 44332211", res_data); end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL t1_handoff got vld=%b rdy=%b want 0 1", res_valid, req_ready); end
  endtask

  task automatic test_gaps_backpressure();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_job();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t2_early_valid got %b want 0", res_valid); end
      end
      repeat (3) cyc();
      send_word(w[i]);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (res_valid !== 1'b1 || res_data !== 32'h44332211) begin
        n_bad++; $display("FAIL t2_hold%0d got vld=%b data=%h want 1 44332211", i, res_valid, res_data); end
      cyc();
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t2_release got vld=%b rdy=%b busy=%b want 0 1 0", res_valid, req_ready, busy); end
  endtask

  task automatic test_stray();
    send_word(8'hAA);
    n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL t3_stray_idle got %b want 1", err_stray); end
    n_cmp++; if (res_data !== 32'h44332211) begin n_bad++; $display("FAIL t3_data_idle got %h want 44332211", res_data); end
    cyc();
    n_cmp++; if (err_stray !== 1'b0) begin n_bad++; $display("FAIL t3_stray_pulse got %b want 0", err_stray); end
    start_job();
    send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
    n_cmp++; if (res_data !== 32'h04030201 || res_valid !== 1'b1) begin
      n_bad++; $display("FAIL t3_job got vld=%b data=%h want 1 04030201", res_valid, res_data); end
    send_word(8'hAA);
    n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL t3_stray_hold got %b want 1", err_stray); end
    n_cmp++; if (res_data !== 32'h04030201 || res_valid !== 1'b1) begin
      n_bad++; $display("FAIL t3_data_hold got vld=%b data=%h want 1 04030201", res_valid, res_data); end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int  waited;
    bit  seen_vld;
    bit  seen_tmo;
    waited = 0; seen_vld = 0; seen_tmo = 0;
    start_job();
    send_word(8'h5A); send_word(8'h6B);
    while (!seen_tmo && waited < 40) begin
      cyc();
      waited++;
      if (res_valid) seen_vld = 1;
      if (err_timeout) seen_tmo = 1;
    end
    n_cmp++; if (!seen_tmo || waited != 20) begin
      n_bad++; $display("FAIL t4_timeout got seen=%0d after %0d cycles want 1 after 20", seen_tmo, waited); end
    n_cmp++; if (seen_vld) begin n_bad++; $display("FAIL t4_no_valid got res_valid seen want never"); end
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t4_idle got rdy=%b busy=%b want 1 0", req_ready, busy); end
    cyc();
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL t4_pulse got %b want 0", err_timeout); end
  endtask

  task automatic test_abort();
    start_job();
    send_word(8'h01); send_word(8'h02); send_word(8'h03);
    abort = 1'b1;
    send_word(8'h04);
    abort = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL t5_abort_last got vld=%b rdy=%b want 0 1", res_valid, req_ready); end
    cyc();
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL t5_abort_last_late got %b want 0", res_valid); end
    start_job();
    send_word(8'h0A); send_word(8'h0B); send_word(8'h0C); send_word(8'h0D);
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL t5_hold got %b want 1", res_valid); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL t5_abort_hold got vld=%b rdy=%b want 0 1", res_valid, req_ready); end
  endtask

  task automatic test_async_reset();
    start_job();
    send_word(8'hEE); send_word(8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0 || me_start !== 1'b0) begin
      n_bad++; $display("FAIL t6_async got busy=%b rdy=%b vld=%b start=%b want 0 1 0 0", busy, req_ready, res_valid, me_start); end
    n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL t6_data_clr got %h want 00000000", res_data); end
    cyc();
    rst_n = 1'b1;
    cyc();
    start_job();
    send_word(8'h5A); send_word(8'h6B); send_word(8'h7C); send_word(8'h8D);
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 32'h8D7C6B5A) begin
      n_bad++; $display("FAIL t6_fresh got vld=%b data=%h want 1 8D7C6B5A", res_valid, res_data); end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps_backpressure();
    test_stray();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
